// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one fixed-latency 32-bit multiplier among NUM_REQ requesters.
// Define MULT_ARB_RR_EN for round-robin arbitration; otherwise the lowest index always wins.
module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_in1,
    input  logic [32*NUM_REQ-1:0]   req_in2,
    output logic [NUM_REQ-1:0]      req_grant,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [31:0]             resp_data,
    output logic [31:0]             mul_in1,
    output logic [31:0]             mul_in2,
    output logic                    mul_tstart,
    input  logic [31:0]             mul_out,
    output logic [31:0]             ops_issued
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_REQ-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            r = v[k] ? IDX_W'(k) : r;
        end
        return r;
    endfunction

    // Addition modulo NUM_REQ for index arithmetic (operands are already < NUM_REQ).
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                  input logic [IDX_W-1:0] b);
        logic [IDX_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= (IDX_W+1)'(NUM_REQ)) begin
            return IDX_W'(sum - (IDX_W+1)'(NUM_REQ));
        end else begin
            return IDX_W'(sum);
        end
    endfunction

    logic                   grant_any_s;
    logic [IDX_W-1:0]       grant_idx_s;
    logic                   tag_valid_r [LATENCY];
    logic [IDX_W-1:0]       tag_idx_r   [LATENCY];
    logic [31:0]            ops_issued_r;

`ifdef MULT_ARB_RR_EN
    logic [IDX_W-1:0]       ptr_r;
    logic [NUM_REQ-1:0]     rot_s;

    // Round-robin search: rotate requests so bit 0 is the requester at ptr.
    always_comb begin
        rot_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rot_s[k] = req_valid[wrap_add(ptr_r, IDX_W'(k))];
        end
        grant_any_s = (|req_valid) && !rst;
        grant_idx_s = wrap_add(ptr_r, lowest_set(rot_s));
    end

    // Priority pointer moves just past the last granted requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (grant_any_s) begin
            ptr_r <= wrap_add(grant_idx_s, IDX_W'(1));
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    // Fixed priority search: lowest requesting index wins.
    always_comb begin
        grant_any_s = (|req_valid) && !rst;
        grant_idx_s = lowest_set(req_valid);
    end
`endif

    // Grant vector and multiplier operand mux.
    always_comb begin
        req_grant  = '0;
        mul_tstart = grant_any_s;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_grant[k] = grant_any_s && (grant_idx_s == IDX_W'(k));
        end
        if (grant_any_s) begin
            mul_in1 = req_in1[32*int'(grant_idx_s) +: 32];
            mul_in2 = req_in2[32*int'(grant_idx_s) +: 32];
        end else begin
            mul_in1 = 32'd0;
            mul_in2 = 32'd0;
        end
    end

    // Tag pipeline mirrors the multiplier latency so each result is routed to its owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LATENCY; s++) begin
                tag_valid_r[s] <= 1'b0;
                tag_idx_r[s]   <= '0;
            end
        end else begin
            tag_valid_r[0] <= grant_any_s;
            tag_idx_r[0]   <= grant_idx_s;
            for (int s = 1; s < LATENCY; s++) begin
                tag_valid_r[s] <= tag_valid_r[s-1];
                tag_idx_r[s]   <= tag_idx_r[s-1];
            end
        end
    end

    // Response steering from the pipeline tail.
    always_comb begin
        resp_valid = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            resp_valid[k] = tag_valid_r[LATENCY-1] && (tag_idx_r[LATENCY-1] == IDX_W'(k));
        end
        if (tag_valid_r[LATENCY-1]) begin
            resp_data = mul_out;
        end else begin
            resp_data = 32'd0;
        end
    end

    // Free-running count of accepted operand pairs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_issued_r <= 32'd0;
        end else if (grant_any_s) begin
            ops_issued_r <= ops_issued_r + 32'd1;
        end else begin
            ops_issued_r <= ops_issued_r;
        end
    end

    assign ops_issued = ops_issued_r;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter; models the shared multiplier.
// Expectations follow MULT_ARB_RR_EN the same way the design does.
module tb_mult_share_arbiter;
    localparam int NR  = 4;
    localparam int LAT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [32*NR-1:0]  req_in1;
    logic [32*NR-1:0]  req_in2;
    logic [NR-1:0]     req_grant;
    logic [NR-1:0]     resp_valid;
    logic [31:0]       resp_data;
    logic [31:0]       mul_in1;
    logic [31:0]       mul_in2;
    logic              mul_tstart;
    logic [31:0]       mul_out;
    logic [31:0]       ops_issued;

    int n_cmp = 0;
    int n_bad = 0;

    mult_share_arbiter #(.NUM_REQ(NR), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_in1(req_in1), .req_in2(req_in2),
        .req_grant(req_grant), .resp_valid(resp_valid), .resp_data(resp_data),
        .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_tstart(mul_tstart),
        .mul_out(mul_out), .ops_issued(ops_issued)
    );

    always #5 clk = ~clk;

    // Multiplier model: product of the issued operands appears LAT cycles later.
    logic [31:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= mul_in1 * mul_in2;
        for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_out = mpipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_in1[32*i +: 32] = a;
        req_in2[32*i +: 32] = b;
    endtask

    task automatic do_reset();
        next();
        rst = 1'b1;
        req_valid = '0;
        next();
        rst = 1'b0;
    endtask

    logic [31:0] prod [NR];

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_in1 = '0;
        req_in2 = '0;

        // Reset: grants and operands forced low even with requests pending
        next();
        req_valid = 4'hF;
        set_ops(0, 32'd3, 32'd5);
        mid();
        chk("rst_grant", 32'(req_grant), 32'd0);
        chk("rst_tstart", 32'(mul_tstart), 32'd0);
        chk("rst_in1", mul_in1, 32'd0);
        chk("rst_in2", mul_in2, 32'd0);
        next();
        mid();
        chk("rst_ops", ops_issued, 32'd0);
        chk("rst_resp", 32'(resp_valid), 32'd0);
        chk("rst_data", resp_data, 32'd0);
        next();
        rst = 1'b0;
        req_valid = '0;
        mid();
        chk("idle_grant", 32'(req_grant), 32'd0);
        chk("idle_tstart", 32'(mul_tstart), 32'd0);
        chk("idle_in1", mul_in1, 32'd0);

        // Single request from requester 2: 7*6
        next();
        req_valid = 4'b0100;
        set_ops(2, 32'd7, 32'd6);
        mid();
        chk("single_grant", 32'(req_grant), 32'd4);
        chk("single_tstart", 32'(mul_tstart), 32'd1);
        chk("single_in1", mul_in1, 32'd7);
        chk("single_in2", mul_in2, 32'd6);
        chk("single_resp0", 32'(resp_valid), 32'd0);
        for (int c = 1; c <= LAT; c++) begin
            next();
            req_valid = '0;
            mid();
            chk("single_resp", 32'(resp_valid), (c == LAT) ? 32'd4 : 32'd0);
            if (c == LAT) chk("single_data", resp_data, 32'd42);
            if (c == 1) chk("single_ops", ops_issued, 32'd1);
        end

        // All four continuously valid from a fresh reset
        do_reset();
        for (int i = 0; i < NR; i++) set_ops(i, 32'(i + 2), 32'(10 * (i + 1)));
        prod[0] = 32'd20;
        prod[1] = 32'd60;
        prod[2] = 32'd120;
        prod[3] = 32'd200;
        for (int c = 0; c < 10; c++) begin
            int eg;
            int er;
`ifdef MULT_ARB_RR_EN
            eg = c % NR;
            er = (c >= LAT) ? (c - LAT) % NR : 0;
`else
            eg = 0;
            er = 0;
`endif
            next();
            req_valid = (c < 6) ? 4'hF : 4'h0;
            mid();
            chk("all_grant", 32'(req_grant), (c < 6) ? (32'd1 << eg) : 32'd0);
            chk("all_resp", 32'(resp_valid), (c >= LAT) ? (32'd1 << er) : 32'd0);
            if (c >= LAT) chk("all_data", resp_data, prod[er]);
        end
        chk("all_ops", ops_issued, 32'd6);

        // Pointer wrap: requester 3 alone, then 0 and 3 together
        next();
        req_valid = 4'b1000;
        mid();
        chk("wrap_grant3", 32'(req_grant), 32'd8);
        next();
        req_valid = 4'b1001;
        mid();
        chk("wrap_grant0", 32'(req_grant), 32'd1);
        next();
        req_valid = 4'b0101;
        mid();
`ifdef MULT_ARB_RR_EN
        chk("mode_grant", 32'(req_grant), 32'd4);
        chk("mode_in1", mul_in1, 32'd4);
`else
        chk("mode_grant", 32'(req_grant), 32'd1);
        chk("mode_in1", mul_in1, 32'd2);
`endif

        // Reset while three operations are in flight
        do_reset();
        for (int g = 0; g < 3; g++) begin
            next();
            req_valid = 4'b0001;
            mid();
            chk("flight_grant", 32'(req_grant), 32'd1);
        end
        next();
        rst = 1'b1;
        mid();
        chk("flight_rst_grant", 32'(req_grant), 32'd0);
        chk("flight_rst_tstart", 32'(mul_tstart), 32'd0);
        next();
        rst = 1'b0;
        req_valid = '0;
        mid();
        chk("flight_ops", ops_issued, 32'd0);
        for (int c = 0; c < LAT + 2; c++) begin
            chk("flight_resp", 32'(resp_valid), 32'd0);
            next();
            mid();
        end

        // Counter wrap from all-ones, with a product that overflows 32 bits
        force dut.ops_issued_r = 32'hFFFF_FFFF;
        #1;
        release dut.ops_issued_r;
        chk("cnt_preload", ops_issued, 32'hFFFF_FFFF);
        next();
        req_valid = 4'b0010;
        set_ops(1, 32'h0001_0000, 32'h0001_0001);
        mid();
        chk("cnt_grant", 32'(req_grant), 32'd2);
        for (int c = 1; c <= LAT; c++) begin
            next();
            req_valid = '0;
            mid();
            if (c == 1) chk("cnt_wrap", ops_issued, 32'd0);
            if (c == LAT) chk("cnt_resp", 32'(resp_valid), 32'd2);
            if (c == LAT) chk("cnt_data", resp_data, 32'h0001_0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
